// File: rtl/console_pkg.sv
// Shared constants and types for the console arbiter.
package console_pkg;

    localparam int         CONSOLE_N_DEFAULT = 4;
    localparam logic [7:0] CONSOLE_NL        = 8'h0A;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/console_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last,
// wrapping modulo N. i_last itself is considered last.
module rr_pick
    import console_pkg::*;
#(
    parameter int N = CONSOLE_N_DEFAULT
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_last,
    output logic [N-1:0] o_onehot,
    output logic [2:0]   o_idx,
    output logic         o_any
);

    int w_best;
    int w_dist;

    // Rank every requester by its distance from i_last+1 and keep the nearest.
    always_comb begin
        o_onehot = '0;
        o_idx    = i_last;
        o_any    = |i_req;
        w_best   = N;
        w_dist   = 0;
        for (int j = 0; j < N; j++) begin
            w_dist = (j + 2 * N - int'(i_last) - 1) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_onehot    = '0;
                o_onehot[j] = 1'b1;
                o_idx       = 3'(j);
            end
        end
    end

endmodule

// File: rtl/console_arbiter.sv
// Console arbiter: N byte-stream requesters share one output register.
// A requester owns the console until it sends a newline or goes quiet for
// IDLE_TIMEOUT cycles; ownership then passes round-robin.
module console_arbiter
    import console_pkg::*;
#(
    parameter int N            = CONSOLE_N_DEFAULT,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_ready,
    output logic [2:0]     grant,
    output logic           locked
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [2:0]   r_grant;
    logic [7:0]   r_idle_cnt;
    logic         r_tx_valid;
    logic [7:0]   r_tx_data;

    logic         w_own_valid;
    logic [7:0]   w_own_data;
    logic         w_sink_free;
    logic         w_accept;
    logic [N-1:0] w_pick_onehot;
    logic [2:0]   w_pick_idx;
    logic         w_pick_any;

    rr_pick #(.N(N)) u_pick (
        .i_req    (req_valid),
        .i_last   (r_grant),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Owner's valid/byte, selected by the grant index.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (r_grant == 3'(i)) begin
                w_own_valid = req_valid[i];
                w_own_data  = req_data[8*i +: 8];
            end
        end
    end

    // Output register can take a byte when empty or draining this cycle.
    assign w_sink_free = !r_tx_valid || tx_ready;

    // Next state, ready fan-out and accept strobe.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) w_state_nxt = LOCKED;
            end
            LOCKED: begin
                for (int i = 0; i < N; i++)
                    req_ready[i] = (r_grant == 3'(i)) && w_sink_free;
                w_accept = w_own_valid && w_sink_free;
                if (w_accept && (w_own_data == CONSOLE_NL))
                    w_state_nxt = IDLE;
                else if (!w_own_valid && (r_idle_cnt == TIMEOUT_LAST))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Grant only moves when IDLE picks a new owner; N-1 at reset so 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_grant <= 3'(N - 1);
        else if (r_state == IDLE && w_pick_any) r_grant <= w_pick_idx;
    end

    // Quiet-cycle counter for the owner; held at zero while IDLE so entry starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_idle_cnt <= 8'd0;
        else if (r_state == IDLE) r_idle_cnt <= 8'd0;
        else if (w_accept)        r_idle_cnt <= 8'd0;
        else if (!w_own_valid)    r_idle_cnt <= r_idle_cnt + 8'd1;
    end

    // Output byte register; a release does not flush it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_own_data;
        end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign grant    = r_grant;
    assign locked   = (r_state == LOCKED);

endmodule
